// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the synchronous instruction
// memory and hands one instruction per cycle to decode.
module fetch_sequencer #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  state_out,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic        pend_valid, pend_valid_n;
  logic        fault_q, fault_n;
  logic [31:0] count, count_n;
  logic        launch;
  logic        oor;

  // Address mux: redirect first, replay while stalled, else sequential.
  always_comb begin
    if (redirect_valid)
      imem_addr = redirect_pc;
    else if (stall && pend_valid)
      imem_addr = pend_pc;
    else
      imem_addr = fetch_pc;
  end

  assign oor = (imem_addr >= DEPTH);

  // Next-state: decide whether this edge launches a read, then apply it.
  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    pend_pc_n    = pend_pc;
    pend_valid_n = pend_valid;
    fault_n      = fault_q;
    launch       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || redirect_valid)
          launch = 1'b1;
      end
      RUN: begin
        if (redirect_valid) begin
          launch = 1'b1;
        end else if (halt) begin
          state_n      = HALT;
          pend_valid_n = 1'b0;
        end else if (!stall) begin
          launch = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid)
          launch = 1'b1;
      end
      default: begin
        state_n      = IDLE;
        pend_valid_n = 1'b0;
      end
    endcase
    if (launch) begin
      if (oor) begin
        state_n      = HALT;
        fault_n      = 1'b1;
        pend_valid_n = 1'b0;
      end else begin
        state_n      = RUN;
        fault_n      = 1'b0;
        pend_pc_n    = imem_addr;
        pend_valid_n = 1'b1;
        fetch_pc_n   = imem_addr + 32'd1;
      end
    end
    count_n = (pend_valid && !stall) ? count + 32'd1 : count;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pend_pc    <= 32'h0;
      pend_valid <= 1'b0;
      fault_q    <= 1'b0;
      count      <= 32'h0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      pend_pc    <= pend_pc_n;
      pend_valid <= pend_valid_n;
      fault_q    <= fault_n;
      count      <= count_n;
    end
  end

  assign instr_out   = pend_valid ? imem_data : 32'h0;
  assign pc_out      = pend_pc;
  assign instr_valid = pend_valid;
  assign fault       = fault_q;
  assign state_out   = state;
  assign fetch_count = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: word-addressed memory model with
// word i = i+1 and a scoreboard of consumed PCs.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  state_out;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sbq[$];
  logic [31:0] mem [256];

  fetch_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .fault          (fault),
    .state_out      (state_out),
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 32'(i + 1);
  end

  always @(posedge clock)
    imem_data <= mem[imem_addr[7:0]];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (instr_valid === 1'b1 && stall === 1'b0) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", pc_out, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sbq.pop_front();
        chk("sb_pc", pc_out, e);
        chk("sb_instr", instr_out, e + 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    for (int i = 0; i < 10; i++)
      sbq.push_back(32'(i));
    sbq.push_back(32'd24);
    sbq.push_back(32'd40);
    sbq.push_back(32'd0);
    for (int i = 250; i < 256; i++)
      sbq.push_back(32'(i));
    sbq.push_back(32'd10);
    sbq.push_back(32'd11);

    tick(2);
    reset = 1'b0;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", pc_out, 32'd0);
    chk("first_instr", instr_out, 32'd1);
    tick(5);
    chk("pre_stall_pc", pc_out, 32'd5);
    chk("pre_stall_cnt", fetch_count, 32'd5);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("stall_pc", pc_out, 32'd5);
      chk("stall_instr", instr_out, 32'd6);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    chk("stall_cnt", fetch_count, 32'd5);
    tick(1);
    chk("post_stall_pc", pc_out, 32'd6);
    chk("post_stall_cnt", fetch_count, 32'd6);
    tick(3);
    chk("pre_redir_pc", pc_out, 32'd9);

    redirect_valid = 1'b1;
    redirect_pc = 32'd24;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_pc", pc_out, 32'd24);
    chk("redir_instr", instr_out, 32'd25);
    tick(1);
    chk("redir_next_pc", pc_out, 32'd25);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    tick(1);
    stall = 1'b0;
    redirect_valid = 1'b0;
    chk("redir_stall_pc", pc_out, 32'd40);
    chk("redir_stall_instr", instr_out, 32'd41);

    redirect_valid = 1'b1;
    redirect_pc = 32'd300;
    tick(1);
    redirect_valid = 1'b0;
    chk("oor_state", 32'(state_out), 32'd2);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_valid", 32'(instr_valid), 32'd0);
    chk("oor_instr", instr_out, 32'd0);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("halt_start", 32'(state_out), 32'd2);
    chk("halt_valid", 32'(instr_valid), 32'd0);

    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    tick(1);
    redirect_valid = 1'b0;
    chk("resume_state", 32'(state_out), 32'd1);
    chk("resume_fault", 32'(fault), 32'd0);
    chk("resume_pc", pc_out, 32'd0);

    redirect_valid = 1'b1;
    redirect_pc = 32'd250;
    tick(1);
    redirect_valid = 1'b0;
    chk("end_pc250", pc_out, 32'd250);
    tick(5);
    chk("end_pc255", pc_out, 32'd255);
    chk("end_instr255", instr_out, 32'd256);
    tick(1);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_state", 32'(state_out), 32'd2);
    chk("end_valid", 32'(instr_valid), 32'd0);

    redirect_valid = 1'b1;
    redirect_pc = 32'd10;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    chk("mid_pc", pc_out, 32'd11);
    chk("mid_state", 32'(state_out), 32'd1);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_state", 32'(state_out), 32'd0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_instr", instr_out, 32'd0);
    chk("mrst_pc", pc_out, 32'd0);
    chk("mrst_fault", 32'(fault), 32'd0);
    chk("mrst_count", fetch_count, 32'd0);
    tick(1);
    chk("idle_hold", 32'(state_out), 32'd0);
    chk("sb_left", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
